// File: rtl/pss_mem_arb_pkg.sv
// Shared types and helpers for the pss_memsplit three-master memory arbiter.
package pss_mem_arb_pkg;

    typedef logic [1:0] mid_t;

    localparam mid_t MID_UDM   = 2'd0;
    localparam mid_t MID_DATA  = 2'd1;
    localparam mid_t MID_INSTR = 2'd2;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Saturating wait counter: clears whenever the master is not left waiting.
    function automatic logic [7:0] starve_next(input logic waiting_i,
                                               input logic [7:0] cnt_i,
                                               input logic [7:0] limit_i);
        logic [7:0] nxt;
        if (!waiting_i) begin
            nxt = 8'd0;
        end else if (cnt_i == limit_i) begin
            nxt = cnt_i;
        end else begin
            nxt = cnt_i + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pss_mem_arb_idfifo.sv
// In-order FIFO of master ids for outstanding reads; full/empty come from
// registered occupancy so a same-cycle pop never frees a slot for a push.
module pss_mem_arb_idfifo
    import pss_mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic push_i,
    input  mid_t push_id_i,
    input  logic pop_i,
    output mid_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    mid_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (cnt_q == DEPTH_C);
    assign empty_o   = (cnt_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= MID_UDM;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (do_push_s) begin
                mem_q[wptr_q] <= push_id_i;
            end
        end
    end

endmodule

// File: rtl/pss_mem_arb.sv
// Fixed-priority arbiter (m0 > m1 > m2) with starvation promotion, request
// lock until slave ack, and in-order read response routing.
module pss_mem_arb
    import pss_mem_arb_pkg::*;
#(
    parameter int RESP_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT    = 15,
    parameter int ADDR_W          = 32
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [3:0]        m0_be_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_ack_o,
    output logic              m0_resp_o,
    output logic [31:0]       m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [3:0]        m1_be_i,
    input  logic [31:0]       m1_wdata_i,
    output logic              m1_ack_o,
    output logic              m1_resp_o,
    output logic [31:0]       m1_rdata_o,
    input  logic              m2_req_i,
    input  logic              m2_we_i,
    input  logic [ADDR_W-1:0] m2_addr_i,
    input  logic [3:0]        m2_be_i,
    input  logic [31:0]       m2_wdata_i,
    output logic              m2_ack_o,
    output logic              m2_resp_o,
    output logic [31:0]       m2_rdata_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [3:0]        s_be_o,
    output logic [31:0]       s_wdata_o,
    input  logic              s_ack_i,
    input  logic              s_resp_i,
    input  logic [31:0]       s_rdata_i,
    output logic              resp_err_o
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    arb_state_e state_q, state_d;
    mid_t       lock_id_q, lock_id_d;
    logic [7:0] starve1_q, starve1_d;
    logic [7:0] starve2_q, starve2_d;
    logic       resp_err_q, resp_err_d;

    mid_t       win_s;
    mid_t       head_s;
    logic       lock_req_s;
    logic       drop_s;
    logic       s_req_s;
    logic       grant_s;
    logic       push_s;
    logic       pop_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;

    pss_mem_arb_idfifo #(
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_idfifo (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .push_i    (push_s),
        .push_id_i (win_s),
        .pop_i     (pop_s),
        .head_o    (head_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    always_comb begin
        case (lock_id_q)
            MID_UDM:   lock_req_s = m0_req_i;
            MID_DATA:  lock_req_s = m1_req_i;
            MID_INSTR: lock_req_s = m2_req_i;
            default:   lock_req_s = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ARB_OPEN;
            lock_id_q <= MID_UDM;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ARB_OPEN: begin
                if (s_req_s && !s_ack_i) begin
                    state_d   = ARB_LOCKED;
                    lock_id_d = win_s;
                end else begin
                    state_d   = ARB_OPEN;
                end
            end
            ARB_LOCKED: begin
                if (!lock_req_s || s_ack_i) begin
                    state_d = ARB_OPEN;
                end else begin
                    state_d = ARB_LOCKED;
                end
            end
            default: state_d = ARB_OPEN;
        endcase
    end

    // A locked master that abandons its request gets no grant this cycle;
    // open arbitration restarts once the lock has cleared.
    always_comb begin
        win_s  = MID_UDM;
        drop_s = 1'b0;
        case (state_q)
            ARB_LOCKED: begin
                win_s  = lock_id_q;
                drop_s = !lock_req_s;
            end
            ARB_OPEN: begin
                if (m1_req_i && (starve1_q == STARVE_MAX)) begin
                    win_s = MID_DATA;
                end else if (m2_req_i && (starve2_q == STARVE_MAX)) begin
                    win_s = MID_INSTR;
                end else if (m0_req_i) begin
                    win_s = MID_UDM;
                end else if (m1_req_i) begin
                    win_s = MID_DATA;
                end else begin
                    win_s = MID_INSTR;
                end
            end
            default: begin
                win_s  = MID_UDM;
                drop_s = 1'b0;
            end
        endcase
    end

    assign s_req_s = (m0_req_i || m1_req_i || m2_req_i) && !fifo_full_s && !drop_s && !arst_i;
    assign s_req_o = s_req_s;
    assign grant_s = s_req_s && s_ack_i;
    assign push_s  = grant_s && !s_we_o;
    assign pop_s   = s_resp_i && !fifo_empty_s;

    always_comb begin
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_be_o    = 4'h0;
        s_wdata_o = 32'h0;
        if (s_req_s) begin
            case (win_s)
                MID_UDM: begin
                    s_we_o = m0_we_i;  s_addr_o = m0_addr_i;
                    s_be_o = m0_be_i;  s_wdata_o = m0_wdata_i;
                end
                MID_DATA: begin
                    s_we_o = m1_we_i;  s_addr_o = m1_addr_i;
                    s_be_o = m1_be_i;  s_wdata_o = m1_wdata_i;
                end
                MID_INSTR: begin
                    s_we_o = m2_we_i;  s_addr_o = m2_addr_i;
                    s_be_o = m2_be_i;  s_wdata_o = m2_wdata_i;
                end
                default: begin
                    s_we_o = 1'b0;     s_addr_o = '0;
                    s_be_o = 4'h0;     s_wdata_o = 32'h0;
                end
            endcase
        end else begin
            s_we_o    = 1'b0;
            s_addr_o  = '0;
            s_be_o    = 4'h0;
            s_wdata_o = 32'h0;
        end
    end

    assign m0_ack_o   = grant_s && (win_s == MID_UDM);
    assign m1_ack_o   = grant_s && (win_s == MID_DATA);
    assign m2_ack_o   = grant_s && (win_s == MID_INSTR);

    assign m0_resp_o  = pop_s && (head_s == MID_UDM);
    assign m1_resp_o  = pop_s && (head_s == MID_DATA);
    assign m2_resp_o  = pop_s && (head_s == MID_INSTR);
    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;
    assign m2_rdata_o = s_rdata_i;

    always_comb begin
        starve1_d  = starve_next(m1_req_i && !m1_ack_o, starve1_q, STARVE_MAX);
        starve2_d  = starve_next(m2_req_i && !m2_ack_o, starve2_q, STARVE_MAX);
        if (s_resp_i && fifo_empty_s) begin
            resp_err_d = 1'b1;
        end else begin
            resp_err_d = resp_err_q;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            starve1_q  <= 8'd0;
            starve2_q  <= 8'd0;
            resp_err_q <= 1'b0;
        end else begin
            starve1_q  <= starve1_d;
            starve2_q  <= starve2_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err_o = resp_err_q;

endmodule

// File: tb/tb_pss_mem_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a queue-based reference model of the arbiter.
`timescale 1ns/1ps
module tb_pss_mem_arb;

    localparam int DEPTH = 4;
    localparam int LIMIT = 15;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [2:0]  req, we;
    logic [31:0] addr [3];
    logic [3:0]  be [3];
    logic [31:0] wdata [3];
    logic [2:0]  ack, resp;
    logic [31:0] rdata [3];
    logic        s_req, s_we, s_ack, s_resp, err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int       lock_m;
    int       starve [3];
    int       idq [$];
    bit       err_m;
    bit [2:0] got_ack;

    always #5 clk = ~clk;

    pss_mem_arb #(.RESP_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
        .clk_i(clk), .arst_i(arst),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_be_i(be[0]),
        .m0_wdata_i(wdata[0]), .m0_ack_o(ack[0]), .m0_resp_o(resp[0]), .m0_rdata_o(rdata[0]),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_be_i(be[1]),
        .m1_wdata_i(wdata[1]), .m1_ack_o(ack[1]), .m1_resp_o(resp[1]), .m1_rdata_o(rdata[1]),
        .m2_req_i(req[2]), .m2_we_i(we[2]), .m2_addr_i(addr[2]), .m2_be_i(be[2]),
        .m2_wdata_i(wdata[2]), .m2_ack_o(ack[2]), .m2_resp_o(resp[2]), .m2_rdata_o(rdata[2]),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata), .resp_err_o(err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_eval(output bit e_sreq, output int win,
                                       output bit [2:0] e_ack, output bit [2:0] e_resp);
        bit dropped;
        dropped = 1'b0;
        win = 0;
        if (lock_m >= 0) begin
            win = lock_m;
            dropped = !req[lock_m];
        end else if (req[1] && starve[1] == LIMIT) win = 1;
        else if (req[2] && starve[2] == LIMIT) win = 2;
        else if (req[0]) win = 0;
        else if (req[1]) win = 1;
        else win = 2;
        e_sreq = !arst && (req != 3'b000) && (idq.size() < DEPTH) && !dropped;
        e_ack = 3'b000;
        if (e_sreq && s_ack) e_ack[win] = 1'b1;
        e_resp = 3'b000;
        if (!arst && s_resp && idq.size() > 0) e_resp[idq[0]] = 1'b1;
    endfunction

    task automatic model_reset();
        lock_m = -1;
        starve[0] = 0; starve[1] = 0; starve[2] = 0;
        idq.delete();
        err_m = 1'b0;
        got_ack = 3'b000;
    endtask

    task automatic model_update();
        bit e_sreq; int win; bit [2:0] e_ack, e_resp;
        if (!arst) begin
            model_eval(e_sreq, win, e_ack, e_resp);
            got_ack = e_ack;
            for (int i = 1; i < 3; i++) begin
                if (req[i] && !e_ack[i]) starve[i] = (starve[i] < LIMIT) ? starve[i] + 1 : LIMIT;
                else starve[i] = 0;
            end
            if (lock_m >= 0) begin
                if (!req[lock_m] || s_ack) lock_m = -1;
            end else if (e_sreq && !s_ack) begin
                lock_m = win;
            end
            if (s_resp) begin
                if (idq.size() > 0) void'(idq.pop_front());
                else err_m = 1'b1;
            end
            if (e_sreq && s_ack && !we[win]) idq.push_back(win);
        end
    endtask

    task automatic compare_model();
        bit e_sreq; int win; bit [2:0] e_ack, e_resp;
        model_eval(e_sreq, win, e_ack, e_resp);
        chk("s_req", s_req, e_sreq);
        if (e_sreq) begin
            chk("s_we", s_we, we[win]);
            chk("s_addr", s_addr, addr[win]);
            chk("s_be", s_be, be[win]);
            chk("s_wdata", s_wdata, wdata[win]);
        end
        chk("acks", ack, e_ack);
        chk("resps", resp, e_resp);
        for (int i = 0; i < 3; i++) begin
            if (e_resp[i]) chk("rdata", rdata[i], s_rdata);
        end
        chk("resp_err", err, err_m);
    endtask

    task automatic eval_cycle();
        @(negedge clk);
        compare_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        eval_cycle();
        advance();
    endtask

    task automatic set_m(input int i, input bit r, input bit w, input logic [31:0] a);
        req[i] = r; we[i] = w; addr[i] = a; be[i] = 4'hF; wdata[i] = a ^ 32'h5A5A_0000;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        model_reset();
        repeat (2) cyc();
        arst = 1'b0;
    endtask

    initial begin : stim
        int n2;
        req = 3'b000; we = 3'b000; s_ack = 1'b0; s_resp = 1'b0; s_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 32'h0; be[i] = 4'h0; wdata[i] = 32'h0;
        end
        model_reset();
        #1;
        do_reset();

        // Single read from m2, response two cycles later
        set_m(2, 1'b1, 1'b0, 32'h100); s_ack = 1'b1;
        eval_cycle();
        chk("t1_ack2", ack[2], 1'b1);
        chk("t1_addr", s_addr, 32'h100);
        advance();
        req[2] = 1'b0; s_ack = 1'b0;
        cyc();
        s_resp = 1'b1; s_rdata = 32'hDEAD_BEEF;
        eval_cycle();
        chk("t1_resp2", resp[2], 1'b1);
        chk("t1_rdata2", rdata[2], 32'hDEAD_BEEF);
        chk("t1_resp01", resp[1:0], 2'b00);
        advance();
        s_resp = 1'b0;

        // Fixed priority and in-order routing
        set_m(0, 1'b1, 1'b0, 32'h10); set_m(1, 1'b1, 1'b0, 32'h20); set_m(2, 1'b1, 1'b0, 32'h30);
        s_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [2:0] oh;
            oh = 3'b001 << k;
            eval_cycle();
            chk("t2_grant", ack, oh);
            advance();
            req[k] = 1'b0;
        end
        chk("t2_model_fifo", idq.size(), 3);
        s_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [2:0] oh;
            oh = 3'b001 << k;
            s_resp = 1'b1; s_rdata = 32'hA0 + k;
            eval_cycle();
            chk("t2_route", resp, oh);
            advance();
        end
        s_resp = 1'b0;

        // Lock held on m2 while the slave stalls
        set_m(2, 1'b1, 1'b1, 32'h200); s_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) set_m(0, 1'b1, 1'b1, 32'h300);
            s_ack = (k == 3);
            eval_cycle();
            chk("t3_addr", s_addr, 32'h200);
            chk("t3_ack2", ack[2], (k == 3));
            advance();
        end
        req[2] = 1'b0;
        eval_cycle();
        chk("t3_m0_next", ack[0], 1'b1);
        chk("t3_addr_m0", s_addr, 32'h300);
        advance();
        req[0] = 1'b0;

        // Starvation promotion of m2 against a continuous m0
        set_m(0, 1'b1, 1'b1, 32'h400); set_m(2, 1'b1, 1'b1, 32'h500); s_ack = 1'b1;
        n2 = 0;
        for (int n = 1; n <= 17; n++) begin
            eval_cycle();
            if (n == 17) chk("t4_m0_resume", ack[0], 1'b1);
            if (ack[2] && n2 == 0) n2 = n;
            advance();
            if (n2 != 0) req[2] = 1'b0;
        end
        chk("t4_starve_cycle", n2, 16);
        req[0] = 1'b0;

        // FIFO full blocks requests; a pop frees a slot only next cycle
        set_m(1, 1'b1, 1'b0, 32'h600); s_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eval_cycle();
            chk("t5_fill", ack[1], 1'b1);
            advance();
            addr[1] = addr[1] + 32'h4;
        end
        eval_cycle();
        chk("t5_full_sreq", s_req, 1'b0);
        advance();
        s_resp = 1'b1; s_rdata = 32'h1111_0000;
        eval_cycle();
        chk("t5_pop_sreq", s_req, 1'b0);
        chk("t5_pop_resp", resp[1], 1'b1);
        advance();
        s_resp = 1'b0;
        eval_cycle();
        chk("t5_after_sreq", s_req, 1'b1);
        chk("t5_after_ack", ack[1], 1'b1);
        advance();
        req[1] = 1'b0; s_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_resp = 1'b1; s_rdata = $urandom;
            cyc();
        end
        s_resp = 1'b0;

        // Unexpected response, then reset with reads outstanding
        s_resp = 1'b1; s_rdata = 32'hBAD0_0001;
        eval_cycle();
        chk("t6_no_resp", resp, 3'b000);
        advance();
        s_resp = 1'b0;
        eval_cycle();
        chk("t6_err_set", err, 1'b1);
        advance();
        set_m(0, 1'b1, 1'b0, 32'h700); s_ack = 1'b1;
        cyc(); cyc();
        req[0] = 1'b0; s_ack = 1'b0;
        cyc();
        chk("t6_model_outstanding", idq.size(), 2);
        req[0] = 1'b1;
        arst = 1'b1;
        model_reset();
        eval_cycle();
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_sreq", s_req, 1'b0);
        chk("t6_rst_acks", ack, 3'b000);
        advance();
        req[0] = 1'b0;
        arst = 1'b0;
        s_resp = 1'b1;
        eval_cycle();
        chk("t6_fifo_emptied", resp, 3'b000);
        advance();
        s_resp = 1'b0;
        eval_cycle();
        chk("t6_err_after_rst", err, 1'b1);
        advance();
        do_reset();

        // Randomized traffic: masters hold req until acked
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i] || got_ack[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req[i] = 1'b1;
                        we[i] = 1'($urandom_range(0, 1));
                        addr[i] = $urandom;
                        be[i] = 4'($urandom);
                        wdata[i] = $urandom;
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            s_ack = (c % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            s_resp = (idq.size() > 0) && ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
